kb_scr_host: RTL and testbench

Far-end agent for the keyboard/screen device driver's external data-bus handshake. Keyboard bytes from a host-side stream are queued and pushed to the driver with its write strobe. Screen bytes the driver presents (inverted on the bus) are captured, de-inverted, queued and offered as a stream. Sits between the terminal/UART bridge and the driver's `data_bus_*`/`control_*` pins. Both directions run independently.

---
 rtl/kb_scr_pkg.sv | 24 ++
 rtl/byte_fifo.sv | 52 +++++
 rtl/kb_scr_host.sv | 164 ++++++++++++++++
 tb/tb_kb_scr_host.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kb_scr_pkg.sv
// Shared types and constants for the keyboard/screen far-end host.
// Bit indices name the driver's control pins as seen from this side of the bus.
package kb_scr_pkg;

    typedef logic [7:0] byte_t;

    typedef enum logic [1:0] {
        T_IDLE,
        T_SETUP,
        T_STROBE,
        T_GAP
    } tx_state_e;

    typedef enum logic {
        R_IDLE,
        R_ACK
    } rx_state_e;

    localparam int CTRL_WR_EN   = 1;
    localparam int CTRL_RD_OK   = 0;
    localparam int STAT_RD_EN_N = 1;
    localparam int STAT_WR_OK_N = 0;

endpackage

// File: rtl/byte_fifo.sv
// Small synchronous byte FIFO with registered storage and first-word-fall-through output.
// A push on a full FIFO is accepted only when a pop happens in the same cycle.
module byte_fifo
    import kb_scr_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  push,
    input  byte_t din,
    input  logic  pop,
    output byte_t dout,
    output logic  full,
    output logic  empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    byte_t       mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    // Extra pointer bit separates full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= din;
                wr_ptr              <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/kb_scr_host.sv
// Far-end agent for the keyboard/screen driver bus: queues keyboard bytes and strobes them out,
// captures inverted screen bytes into a stream. The two directions are fully independent.
module kb_scr_host
    import kb_scr_pkg::*;
#(
    parameter int unsigned KB_DEPTH    = 4,
    parameter int unsigned SCR_DEPTH   = 4,
    parameter int unsigned ACK_TIMEOUT = 255,
    parameter int unsigned GAP         = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] kb_byte_i,
    input  logic       kb_valid_i,
    output logic       kb_ready_o,
    output logic [7:0] scr_byte_o,
    output logic       scr_valid_o,
    input  logic       scr_ready_i,
    output logic [7:0] data_bus_o,
    input  logic [7:0] data_bus_i,
    output logic [1:0] control_o,
    input  logic [1:0] control_i,
    output logic       tx_timeout_o
);

    localparam int unsigned CNT_W = $clog2(ACK_TIMEOUT + GAP + 2);
    localparam logic [CNT_W-1:0] CNT_ONE     = 1;
    localparam logic [CNT_W-1:0] CNT_TIMEOUT = CNT_W'(ACK_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_GAP_END = CNT_W'(GAP - 1);

    tx_state_e        tx_state_q;
    rx_state_e        rx_state_q;
    logic [CNT_W-1:0] cnt_q;
    byte_t            data_bus_q;
    logic             wr_en_q;
    logic             rd_ok_q;
    logic             timeout_q;

    logic  kb_push;
    logic  kb_pop;
    logic  kb_full;
    logic  kb_empty;
    byte_t kb_dout;
    logic  scr_push;
    logic  scr_pop;
    logic  scr_full;
    logic  scr_empty;

    assign kb_ready_o  = !kb_full;
    assign kb_push     = kb_valid_i && !kb_full;
    assign kb_pop      = (tx_state_q == T_IDLE) && !kb_empty;

    assign scr_valid_o = !scr_empty;
    assign scr_pop     = !scr_empty && scr_ready_i;
    // A full screen FIFO leaves the driver presenting its byte until space frees up.
    assign scr_push    = (rx_state_q == R_IDLE) && !control_i[STAT_RD_EN_N] && !scr_full;

    byte_fifo #(
        .DEPTH (KB_DEPTH)
    ) u_kb_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (kb_push),
        .din   (kb_byte_i),
        .pop   (kb_pop),
        .dout  (kb_dout),
        .full  (kb_full),
        .empty (kb_empty)
    );

    byte_fifo #(
        .DEPTH (SCR_DEPTH)
    ) u_scr_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (scr_push),
        .din   (~data_bus_i),
        .pop   (scr_pop),
        .dout  (scr_byte_o),
        .full  (scr_full),
        .empty (scr_empty)
    );

    // cnt_q counts strobe cycles in T_STROBE and gap cycles in T_GAP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_q <= T_IDLE;
            cnt_q      <= '0;
            data_bus_q <= '0;
            wr_en_q    <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            unique case (tx_state_q)
                T_IDLE: begin
                    if (kb_pop) begin
                        data_bus_q <= kb_dout;
                        tx_state_q <= T_SETUP;
                    end
                end
                T_SETUP: begin
                    wr_en_q    <= 1'b1;
                    cnt_q      <= '0;
                    tx_state_q <= T_STROBE;
                end
                T_STROBE: begin
                    if (!control_i[STAT_WR_OK_N]) begin
                        wr_en_q    <= 1'b0;
                        cnt_q      <= '0;
                        tx_state_q <= T_GAP;
                    end else if (cnt_q == CNT_TIMEOUT) begin
                        wr_en_q    <= 1'b0;
                        timeout_q  <= 1'b1;
                        cnt_q      <= '0;
                        tx_state_q <= T_GAP;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                T_GAP: begin
                    if (cnt_q == CNT_GAP_END) begin
                        tx_state_q <= T_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                default: tx_state_q <= T_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state_q <= R_IDLE;
            rd_ok_q    <= 1'b0;
        end else begin
            unique case (rx_state_q)
                R_IDLE: begin
                    if (scr_push) begin
                        rd_ok_q    <= 1'b1;
                        rx_state_q <= R_ACK;
                    end
                end
                R_ACK: begin
                    if (control_i[STAT_RD_EN_N]) begin
                        rd_ok_q    <= 1'b0;
                        rx_state_q <= R_IDLE;
                    end
                end
                default: rx_state_q <= R_IDLE;
            endcase
        end
    end

    always_comb begin
        control_o             = '0;
        control_o[CTRL_WR_EN] = wr_en_q;
        control_o[CTRL_RD_OK] = rd_ok_q;
    end

    assign data_bus_o   = data_bus_q;
    assign tx_timeout_o = timeout_q;

endmodule

// File: tb/tb_kb_scr_host.sv
// Bench for kb_scr_host: vector tables for single transfers, hand sequences for overflow,
// backpressure and mid-transfer reset, and a randomized run scored against queue models.
module tb_kb_scr_host;

    localparam int unsigned ACK_TIMEOUT = 255;
    localparam int unsigned GAP         = 2;
    localparam int          RAND_CYC    = 4000;
    localparam int          DRAIN       = 400;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] kb_byte;
    logic       kb_valid;
    logic       kb_ready;
    logic [7:0] scr_byte;
    logic       scr_valid;
    logic       scr_ready;
    logic [7:0] bus_out;
    logic [7:0] bus_in;
    logic [1:0] ctrl_out;
    logic [1:0] ctrl_in;
    logic       tx_timeout;
    logic       ack_n;
    logic       rd_en_n;

    assign ctrl_in = {rd_en_n, ack_n};

    always #5 clk = ~clk;

    kb_scr_host #(
        .KB_DEPTH    (4),
        .SCR_DEPTH   (4),
        .ACK_TIMEOUT (ACK_TIMEOUT),
        .GAP         (GAP)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .kb_byte_i    (kb_byte),
        .kb_valid_i   (kb_valid),
        .kb_ready_o   (kb_ready),
        .scr_byte_o   (scr_byte),
        .scr_valid_o  (scr_valid),
        .scr_ready_i  (scr_ready),
        .data_bus_o   (bus_out),
        .data_bus_i   (bus_in),
        .control_o    (ctrl_out),
        .control_i    (ctrl_in),
        .tx_timeout_o (tx_timeout)
    );

    typedef struct {
        logic [7:0] kb;
        int         ack_delay;
        logic [7:0] exp_bus;
        int         exp_strobe;
    } tx_vec_t;

    typedef struct {
        logic [7:0] bus;
        logic [7:0] exp_scr;
    } rx_vec_t;

    int n_checks;
    int n_fail;

    logic [7:0] exp_tx[$];
    logic [7:0] exp_rx[$];
    logic [7:0] got[$];
    int         lens[$];
    int         cnt;
    int         run;
    int         tmo;
    logic       bad_hold;
    logic       seen;
    logic       prev;
    logic       acc;
    logic       ok;

    // Random-phase per-process state
    logic       tm_prev;
    logic [7:0] tm_cur;
    logic [7:0] tm_prev_bus;
    int         tm_hi;
    int         tm_d;
    int         tm_low;
    int         rd_st;
    logic [7:0] rd_b;

    task automatic check_int(input string name, input int act, input int want);
        n_checks++;
        if (act != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, want);
        end
    endtask

    task automatic check_byte(input string name, input logic [7:0] act, input logic [7:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %02h, expected %02h", name, act, want);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        kb_byte   = 8'h00;
        kb_valid  = 1'b0;
        scr_ready = 1'b0;
        bus_in    = 8'hFF;
        ack_n     = 1'b1;
        rd_en_n   = 1'b1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    // Driver side of one screen transfer: present, wait for read_ok, release, wait for it to drop.
    task automatic rx_send(input logic [7:0] b);
        bus_in  = ~b;
        rd_en_n = 1'b0;
        ok      = 1'b0;
        for (int w = 0; w < 20; w++) begin
            tick();
            if (ctrl_out[0]) begin
                ok = 1'b1;
                break;
            end
        end
        rd_en_n = 1'b1;
        for (int w = 0; w < 20; w++) begin
            tick();
            if (!ctrl_out[0]) break;
        end
        check_bit("rx_send_ack", ok, 1'b1);
    endtask

    initial begin
        tx_vec_t tx_tab[4];
        rx_vec_t rx_tab[4];

        tx_tab[0] = '{kb: 8'h41, ack_delay: 3, exp_bus: 8'h41, exp_strobe: 4};
        tx_tab[1] = '{kb: 8'h00, ack_delay: 0, exp_bus: 8'h00, exp_strobe: 1};
        tx_tab[2] = '{kb: 8'hFF, ack_delay: 1, exp_bus: 8'hFF, exp_strobe: 2};
        tx_tab[3] = '{kb: 8'hA5, ack_delay: 7, exp_bus: 8'hA5, exp_strobe: 8};

        rx_tab[0] = '{bus: 8'hBE, exp_scr: 8'h41};
        rx_tab[1] = '{bus: 8'h00, exp_scr: 8'hFF};
        rx_tab[2] = '{bus: 8'hFF, exp_scr: 8'h00};
        rx_tab[3] = '{bus: 8'h5A, exp_scr: 8'hA5};

        n_checks = 0;
        n_fail   = 0;

        // Reset values
        do_reset();
        check_byte("rst_control", {6'b0, ctrl_out}, 8'h00);
        check_byte("rst_data_bus", bus_out, 8'h00);
        check_bit("rst_timeout", tx_timeout, 1'b0);
        check_bit("rst_kb_ready", kb_ready, 1'b1);
        check_bit("rst_scr_valid", scr_valid, 1'b0);
        check_byte("rst_scr_byte", scr_byte, 8'h00);

        // Keyboard transfers from the table
        foreach (tx_tab[i]) begin
            kb_byte  = tx_tab[i].kb;
            kb_valid = 1'b1;
            tick();
            kb_valid = 1'b0;
            tick();
            check_byte("tx_setup_bus", bus_out, tx_tab[i].exp_bus);
            check_bit("tx_setup_strobe_low", ctrl_out[1], 1'b0);
            cnt      = 0;
            bad_hold = 1'b0;
            seen     = 1'b0;
            for (int c = 0; c < 40; c++) begin
                tick();
                if (tx_timeout) seen = 1'b1;
                if (ctrl_out[1]) begin
                    cnt++;
                    if (bus_out !== tx_tab[i].exp_bus) bad_hold = 1'b1;
                    if (cnt == tx_tab[i].ack_delay + 1) ack_n = 1'b0;
                end else begin
                    break;
                end
            end
            ack_n = 1'b1;
            check_int("tx_strobe_len", cnt, tx_tab[i].exp_strobe);
            check_bit("tx_bus_hold", bad_hold, 1'b0);
            check_bit("tx_no_timeout", seen, 1'b0);
            repeat (GAP + 2) tick();
            check_byte("tx_bus_retained", bus_out, tx_tab[i].exp_bus);
        end

        // Ack already low when the strobe starts: accepted at the first strobe edge
        ack_n    = 1'b0;
        kb_byte  = 8'h3C;
        kb_valid = 1'b1;
        tick();
        kb_valid = 1'b0;
        tick();
        tick();
        check_bit("tx_early_ack_rise", ctrl_out[1], 1'b1);
        tick();
        check_bit("tx_early_ack_fall", ctrl_out[1], 1'b0);
        ack_n = 1'b1;
        repeat (GAP + 2) tick();

        // Screen transfers from the table
        foreach (rx_tab[i]) begin
            bus_in  = rx_tab[i].bus;
            rd_en_n = 1'b0;
            tick();
            check_bit("rx_ack_set", ctrl_out[0], 1'b1);
            check_bit("rx_valid", scr_valid, 1'b1);
            check_byte("rx_byte", scr_byte, rx_tab[i].exp_scr);
            tick();
            tick();
            check_bit("rx_ack_held", ctrl_out[0], 1'b1);
            rd_en_n = 1'b1;
            tick();
            check_bit("rx_ack_clear", ctrl_out[0], 1'b0);
            scr_ready = 1'b1;
            tick();
            scr_ready = 1'b0;
            check_bit("rx_single_capture", scr_valid, 1'b0);
        end

        // Five keyboard bytes with no acks: FIFO fills, every strobe times out
        do_reset();
        got.delete();
        lens.delete();
        tmo = 0;
        fork
            begin
                for (int b = 1; b <= 5; b++) begin
                    kb_byte  = 8'(b);
                    kb_valid = 1'b1;
                    acc      = 1'b0;
                    for (int w = 0; w < 600 && !acc; w++) begin
                        acc = kb_ready;
                        tick();
                    end
                end
                kb_valid = 1'b0;
                check_bit("kb_full_ready_low", kb_ready, 1'b0);
            end
            begin
                prev = 1'b0;
                run  = 0;
                for (int c = 0; c < 5 * (int'(ACK_TIMEOUT) + 8) + 50; c++) begin
                    tick();
                    if (tx_timeout) tmo++;
                    if (ctrl_out[1] && !prev) got.push_back(bus_out);
                    if (ctrl_out[1]) begin
                        run++;
                    end else if (prev) begin
                        lens.push_back(run);
                        run = 0;
                    end
                    prev = ctrl_out[1];
                end
            end
        join
        check_int("tmo_pulses", tmo, 5);
        check_int("tmo_strobe_count", got.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < got.size()) check_byte("tmo_strobe_byte", got[i], 8'(i + 1));
            if (i < lens.size()) check_int("tmo_strobe_len", lens[i], int'(ACK_TIMEOUT) + 1);
        end
        check_bit("tmo_kb_ready_back", kb_ready, 1'b1);

        // Screen backpressure: fifth byte waits until the consumer frees a slot
        do_reset();
        for (int i = 0; i < 4; i++) rx_send(8'h10 + 8'(i));
        bus_in  = ~8'h14;
        rd_en_n = 1'b0;
        repeat (5) tick();
        check_bit("rx_full_no_ack", ctrl_out[0], 1'b0);
        check_byte("rx_full_head", scr_byte, 8'h10);
        got.delete();
        seen      = 1'b0;
        scr_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (scr_valid) got.push_back(scr_byte);
            if (ctrl_out[0] && !rd_en_n) begin
                seen    = 1'b1;
                rd_en_n = 1'b1;
            end
            tick();
        end
        scr_ready = 1'b0;
        check_bit("rx_fifth_captured", seen, 1'b1);
        check_int("rx_drain_count", got.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < got.size()) check_byte("rx_drain_order", got[i], 8'h10 + 8'(i));
        end

        // Reset asserted during a strobe with another byte still queued
        do_reset();
        rx_send(8'h33);
        kb_byte  = 8'h77;
        kb_valid = 1'b1;
        tick();
        kb_byte = 8'h88;
        tick();
        kb_valid = 1'b0;
        for (int w = 0; w < 10; w++) begin
            if (ctrl_out[1]) break;
            tick();
        end
        check_bit("rst_mid_strobe_active", ctrl_out[1], 1'b1);
        #2 rst = 1'b1;
        #1;
        check_byte("rst_mid_control", {6'b0, ctrl_out}, 8'h00);
        check_bit("rst_mid_kb_ready", kb_ready, 1'b1);
        check_byte("rst_mid_data_bus", bus_out, 8'h00);
        check_bit("rst_mid_scr_valid", scr_valid, 1'b0);
        #2 rst = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (ctrl_out[1]) seen = 1'b1;
        end
        check_bit("rst_no_stale_strobe", seen, 1'b0);
        check_byte("rst_bus_stays_clear", bus_out, 8'h00);

        // Randomized concurrent traffic in both directions
        do_reset();
        exp_tx.delete();
        exp_rx.delete();
        tm_prev     = 1'b0;
        tm_cur      = 8'h00;
        tm_prev_bus = 8'h00;
        tm_hi       = 0;
        tm_d        = 0;
        tm_low      = 100;
        rd_st       = 0;
        rd_b        = 8'h00;
        fork
            begin
                for (int c = 0; c < RAND_CYC; c++) begin
                    @(negedge clk);
                    kb_valid = (c < RAND_CYC - DRAIN) && ($urandom_range(0, 3) != 0);
                    kb_byte  = 8'($urandom);
                    if (kb_valid && kb_ready) exp_tx.push_back(kb_byte);
                end
                kb_valid = 1'b0;
            end
            begin
                for (int c = 0; c < RAND_CYC; c++) begin
                    @(negedge clk);
                    scr_ready = (c >= RAND_CYC - DRAIN) || ($urandom_range(0, 1) == 1);
                    if (scr_valid && scr_ready) begin
                        if (exp_rx.size() == 0) check_bit("rx_rand_unexpected", 1'b1, 1'b0);
                        else check_byte("rx_rand_byte", scr_byte, exp_rx.pop_front());
                    end
                end
            end
            begin
                for (int c = 0; c < RAND_CYC; c++) begin
                    tick();
                    if (ctrl_out[1] && !tm_prev) begin
                        check_bit("tx_rand_gap", tm_low >= int'(GAP), 1'b1);
                        check_byte("tx_rand_setup", bus_out, tm_prev_bus);
                        if (exp_tx.size() == 0) check_bit("tx_rand_unexpected", 1'b1, 1'b0);
                        else check_byte("tx_rand_byte", bus_out, exp_tx.pop_front());
                        tm_cur = bus_out;
                        tm_hi  = 0;
                        tm_d   = int'($urandom_range(0, 5));
                    end
                    if (ctrl_out[1]) begin
                        tm_hi++;
                        check_byte("tx_rand_hold", bus_out, tm_cur);
                        if (tm_hi == tm_d + 1) ack_n = 1'b0;
                        tm_low = 0;
                    end else begin
                        if (tm_prev) begin
                            check_bit("tx_rand_no_timeout", tx_timeout, 1'b0);
                            ack_n = 1'b1;
                        end
                        tm_low++;
                    end
                    tm_prev_bus = bus_out;
                    tm_prev     = ctrl_out[1];
                end
            end
            begin
                for (int c = 0; c < RAND_CYC; c++) begin
                    tick();
                    case (rd_st)
                        0: begin
                            if (c < RAND_CYC - DRAIN && $urandom_range(0, 2) == 0) begin
                                rd_b    = 8'($urandom);
                                bus_in  = ~rd_b;
                                rd_en_n = 1'b0;
                                rd_st   = 1;
                            end
                        end
                        1: begin
                            if (ctrl_out[0]) begin
                                exp_rx.push_back(rd_b);
                                rd_en_n = 1'b1;
                                bus_in  = 8'($urandom);
                                rd_st   = 2;
                            end
                        end
                        default: begin
                            if (!ctrl_out[0]) rd_st = 0;
                        end
                    endcase
                end
            end
        join
        idle_inputs();
        check_int("tx_rand_drained", exp_tx.size(), 0);
        check_int("rx_rand_drained", exp_rx.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
